// File: rtl/dff_register_16.sv
// 16-bit D register with load/byte enables, sync clear and complement out.
// Ports: clk, rst (async hi), d[15:0], en, be[1:0], clr -> q[15:0], q_n[15:0].

module dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic clr,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= rst_val;
    else if (clr)  q <= 1'b0;
    else if (load) q <= d;
  end

endmodule

module dff_register_16 #(
  parameter logic [15:0] RESET_VALUE = 16'h0000,
  parameter int          WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [1:0]       be,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // Byte lanes are hard-wired to two bytes.
  if (WIDTH != 16) begin : g_bad_width
    $error("dff_register_16: WIDTH must be 16");
  end

  logic [1:0] lane_load;

  assign lane_load = be & {2{en}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VALUE[i]),
      .clr     (clr),
      .load    (lane_load[i/8]),
      .d       (d[i]),
      .q       (q[i])
    );
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_dff_register_16.sv
// Bench for dff_register_16: directed vector table, async reset sequences,
// and random loads checked against a byte-lane reference model.

module tb_dff_register_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d   = 16'hFFFF;
  logic        en  = 1'b1;
  logic [1:0]  be  = 2'b11;
  logic        clr = 1'b0;
  logic [15:0] q0, qn0, q1, qn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_register_16 u_dut0 (
    .clk (clk), .rst (rst), .d (d), .en (en),
    .be  (be),  .clr (clr), .q (q0), .q_n (qn0)
  );

  dff_register_16 #(.RESET_VALUE(16'h8000)) u_dut1 (
    .clk (clk), .rst (rst), .d (d), .en (en),
    .be  (be),  .clr (clr), .q (q1), .q_n (qn1)
  );

  typedef struct {
    logic        clr;
    logic        en;
    logic [1:0]  be;
    logic [15:0] d;
    logic [15:0] q;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: clear wins, then each enabled byte lane takes d's byte.
  function automatic logic [15:0] model(input logic [15:0] cur,
                                        input logic c, input logic e,
                                        input logic [1:0] b,
                                        input logic [15:0] din);
    logic [15:0] mask;
    if (c) return 16'h0000;
    if (!e) return cur;
    mask = (b[0] ? 16'h00FF : 16'h0000) | (b[1] ? 16'hFF00 : 16'h0000);
    return (cur & ~mask) | (din & mask);
  endfunction

  initial begin
    logic [15:0] e0, e1;

    tbl[0] = '{1'b0, 1'b1, 2'b11, 16'hA5C3, 16'hA5C3};
    tbl[1] = '{1'b0, 1'b0, 2'b11, 16'h1234, 16'hA5C3};
    tbl[2] = '{1'b0, 1'b0, 2'b11, 16'h1234, 16'hA5C3};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 16'h7E18, 16'hA518};
    tbl[4] = '{1'b0, 1'b1, 2'b10, 16'hBEEF, 16'hBE18};
    tbl[5] = '{1'b0, 1'b1, 2'b00, 16'h0000, 16'hBE18};
    tbl[6] = '{1'b1, 1'b1, 2'b11, 16'hFFFF, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 2'b11, 16'h0F0F, 16'h0F0F};
    tbl[8] = '{1'b1, 1'b0, 2'b00, 16'hAAAA, 16'h0000};
    tbl[9] = '{1'b0, 1'b1, 2'b11, 16'h0F0F, 16'h0F0F};

    // Async reset before any edge, with a full load pending.
    #2 rst = 1'b1;
    #1;
    chk("rst_imm_q0", q0, 16'h0000);
    chk("rst_imm_qn0", qn0, 16'hFFFF);
    chk("rst_imm_q1", q1, 16'h8000);
    chk("rst_imm_qn1", qn1, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_q0", q0, 16'h0000);
      chk("rst_hold_q1", q1, 16'h8000);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Directed table: both instances share inputs and converge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clr = tbl[i].clr;
      en  = tbl[i].en;
      be  = tbl[i].be;
      d   = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q0", i), q0, tbl[i].q);
      chk($sformatf("vec%0d_qn0", i), qn0, ~tbl[i].q);
      chk($sformatf("vec%0d_q1", i), q1, tbl[i].q);
    end

    // Reset raised 2 ns before an edge carrying a load.
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b1;
    be  = 2'b11;
    d   = 16'h1111;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_imm_q1", q1, 16'h8000);
    chk("mid_rst_imm_q0", q0, 16'h0000);
    @(posedge clk); #1;
    chk("mid_rst_edge_q1", q1, 16'h8000);
    chk("mid_rst_edge_qn1", qn1, 16'h7FFF);
    @(negedge clk);
    rst = 1'b0;
    d   = 16'h2222;
    #1;
    chk("rel_no_edge_q1", q1, 16'h8000);
    @(posedge clk); #1;
    chk("rel_load_q1", q1, 16'h2222);
    chk("rel_load_q0", q0, 16'h2222);

    // Random loads against the reference model.
    e0 = 16'h2222;
    e1 = 16'h2222;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d   = 16'($urandom);
      be  = 2'($urandom);
      en  = ($urandom_range(0, 5) != 0);
      clr = ($urandom_range(0, 7) == 0);
      e0  = model(e0, clr, en, be, d);
      e1  = model(e1, clr, en, be, d);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_q0", i), q0, e0);
      chk($sformatf("rnd%0d_qn0", i), qn0, ~e0);
      chk($sformatf("rnd%0d_q1", i), q1, e1);
      chk($sformatf("rnd%0d_qn1", i), qn1, ~e1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
